word_pack_ctrl: RTL and testbench
=================================

Name: word_pack_ctrl

Overview:
Output-side controller for the word decompressor. Accepts variable-length decompressed chunks over a valid/ready handshake and places each one at the current fill position of a 196-bit accumulator, using a barrel_shifter_d2 instance. Emits packed 128-bit words downstream over a second valid/ready handshake. Supports flush of a partial word with zero padding.

Parameters:
IN_WIDTH, 64, max chunk width in bits
OUT_WIDTH, 128, packed output word width
ACC_WIDTH, 196, accumulator width; must be >= OUT_WIDTH-1+IN_WIDTH
SHIFT_BIT, 7, shifter amount width; clog2(OUT_WIDTH)
LEN_BIT, 7, chunk length field width; encodes 0..IN_WIDTH

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream chunk valid
o_ready  out  1  chunk accepted when i_valid&&o_ready
i_chunk  in  IN_WIDTH  chunk data, LSB-first; bits at or above i_len are ignored
i_len  in  LEN_BIT  chunk length in bits; values above IN_WIDTH saturate to IN_WIDTH
i_flush  in  1  single-cycle request to emit the remaining partial word
o_valid  out  1  packed word valid
i_ready  in  1  downstream ready
o_word  out  OUT_WIDTH  packed word; unused MSBs are 0
o_nbits  out  8  valid bits in o_word, 1..128
o_last  out  1  final word of a flush
o_flush_done  out  1  one-cycle pulse when the flush completes
o_fill  out  8  current accumulator fill, for debug/status

Behaviour:
- Reset (async assert, sync release): acc=0, fill=0, flush_pend=0, state=FILL, o_valid=0, o_last=0, o_flush_done=0, o_word=0. o_ready=1 after release.
- State FILL (fill<128 invariant). o_ready=1, o_valid=0.
  - On accept: shifter input = i_chunk masked to len bits, zero-extended; shift amount = fill[6:0].
  - acc <= acc | shifted; fill <= fill+len.
  - len=0 is accepted with no state change.
- Transitions out of FILL, evaluated after the accept update:
  - new fill>=128 -> EMIT.
  - else if i_flush or flush_pend: new fill>0 -> FLUSH; new fill==0 -> o_flush_done pulses next cycle, stay in FILL.
- i_flush arriving in EMIT or FLUSH sets flush_pend. flush_pend clears when o_flush_done fires.
- Chunk accept and i_flush in the same cycle: the chunk is included before the flush.
- State EMIT: o_ready=0, o_valid=1, o_word=acc[127:0], o_nbits=128.
  - o_last=1 only if flush_pend and fill==128.
  - On i_ready: acc <= acc>>128 (zero fill); fill <= fill-128.
  - Next state: FLUSH if flush_pend and remainder>0; else FILL, with o_flush_done pulsed if this was the last flush word.
- State FLUSH: o_ready=0, o_valid=1, o_word=acc[127:0], o_nbits=fill, o_last=1.
  - On i_ready: acc=0, fill=0, flush_pend=0, o_flush_done pulses, -> FILL.
- o_valid, o_word, o_nbits and o_last hold stable while o_valid && !i_ready.
- Latency: a chunk completing a word at accept cycle N gives o_valid at N+1. Throughput: one chunk per cycle while no word is pending; one bubble cycle per emitted word when i_ready=1.
- fill max = 127+64 = 191 < ACC_WIDTH; no overflow is possible. Include an assertion on fill<=191.
- Reset asserted mid-operation: all state is discarded immediately, with no partial output.

Decomposition:
- Package word_pack_pkg:
  - state enum {FILL, EMIT, FLUSH};
  - localparam MAX_FILL=OUT_WIDTH-1+IN_WIDTH;
  - function len_mask(len) returns an IN_WIDTH mask.
- Sub-module: one barrel_shifter_d2 instance (WIDTH=ACC_WIDTH, I_WIDTH=OUT_WIDTH, SHIFT_BIT), fed with the zero-extended masked chunk. All control logic stays in word_pack_ctrl.

Test Plan:
- Four 32-bit chunks 0x11111111..0x44444444, i_ready=1 -> one word 0x44444444_33333333_22222222_11111111, o_nbits=128, o_last=0, fill=0 afterwards.
- Chunks of 100 then 60 bits (i_len saturation checked with i_len=100 -> 64) -> first word emitted after fill reaches 128; remainder fill=0 or correct residual; bits cross the word boundary intact.
- Lengths 60,60,20 (fill 140) -> word of bits[127:0]; residual fill=12 holds chunk-3 bits [19:8] at positions [11:0].
- i_ready held 0 for 5 cycles in EMIT -> o_valid/o_word stable, o_ready=0, no chunk is lost.
- Chunk of 40 bits with i_flush in the same cycle -> FLUSH word o_nbits=40, o_last=1, MSBs zero, o_flush_done one cycle after the handshake.
- i_flush at fill=0 -> no o_valid, o_flush_done next cycle. Reset asserted during EMIT -> o_valid drops asynchronously, fill=0.

Source files
------------

// File: rtl/word_pack_pkg.sv
// Shared sizing, FSM state type and chunk-length mask helper for the word packer.
package word_pack_pkg;

  localparam int IN_WIDTH  = 64;
  localparam int OUT_WIDTH = 128;
  localparam int ACC_WIDTH = 196;
  localparam int SHIFT_BIT = 7;
  localparam int LEN_BIT   = 7;
  localparam int FILL_BIT  = 8;
  localparam int MAX_FILL  = OUT_WIDTH - 1 + IN_WIDTH;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Lengths at or above IN_WIDTH yield an all-ones mask.
  function automatic logic [IN_WIDTH-1:0] len_mask(input logic [LEN_BIT-1:0] len);
    logic [IN_WIDTH-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (len >= LEN_BIT'(IN_WIDTH)) begin
      return '1;
    end
    return (one << len) - one;
  endfunction

endpackage

// File: rtl/barrel_shifter_d2.sv
// Zero-extending left barrel shifter, split into a byte-granular stage and a bit stage.
module barrel_shifter_d2 #(
  parameter int WIDTH     = 196,
  parameter int I_WIDTH   = 128,
  parameter int SHIFT_BIT = 7
) (
  input  logic [I_WIDTH-1:0]   i_data,
  input  logic [SHIFT_BIT-1:0] i_shift,
  output logic [WIDTH-1:0]     o_data
);

  logic [WIDTH-1:0] ext;
  logic [WIDTH-1:0] coarse;

  assign ext    = WIDTH'(i_data);
  assign coarse = ext << {i_shift[SHIFT_BIT-1:3], 3'b000};
  assign o_data = coarse << i_shift[2:0];

endmodule

// File: rtl/word_pack_ctrl.sv
// Packs variable-length chunks into 128-bit output words; supports flushing a
// zero-padded partial word.
module word_pack_ctrl
  import word_pack_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [IN_WIDTH-1:0]  i_chunk,
  input  logic [LEN_BIT-1:0]   i_len,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_word,
  output logic [7:0]           o_nbits,
  output logic                 o_last,
  output logic                 o_flush_done,
  output logic [7:0]           o_fill
);

  state_e                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [FILL_BIT-1:0]   fill_q, fill_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  flush_done_q, flush_done_d;

  logic [LEN_BIT-1:0]    len_sat;
  logic [OUT_WIDTH-1:0]  chunk_ext;
  logic [ACC_WIDTH-1:0]  shifted;
  logic [FILL_BIT-1:0]   new_fill;

  assign len_sat   = (i_len > LEN_BIT'(IN_WIDTH)) ? LEN_BIT'(IN_WIDTH) : i_len;
  assign chunk_ext = OUT_WIDTH'(i_chunk & len_mask(len_sat));
  assign new_fill  = fill_q + FILL_BIT'(len_sat);

  // Shift amount only needs fill[6:0]: chunks are accepted only while fill < 128.
  barrel_shifter_d2 #(
    .WIDTH    (ACC_WIDTH),
    .I_WIDTH  (OUT_WIDTH),
    .SHIFT_BIT(SHIFT_BIT)
  ) u_shifter (
    .i_data (chunk_ext),
    .i_shift(fill_q[SHIFT_BIT-1:0]),
    .o_data (shifted)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= FILL;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    flush_pend_d = flush_pend_q;
    flush_done_d = 1'b0;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    o_word       = '0;
    o_nbits      = '0;
    o_last       = 1'b0;

    unique case (state_q)
      FILL: begin
        o_ready = 1'b1;
        if (i_valid) begin
          acc_d  = acc_q | shifted;
          fill_d = new_fill;
        end
        // fill_d is the post-accept fill, so a same-cycle chunk lands before the flush.
        if (fill_d >= FILL_BIT'(OUT_WIDTH)) begin
          state_d      = EMIT;
          flush_pend_d = flush_pend_q | i_flush;
        end else if (i_flush || flush_pend_q) begin
          if (fill_d != '0) begin
            state_d      = FLUSH;
            flush_pend_d = 1'b1;
          end else begin
            flush_done_d = 1'b1;
            flush_pend_d = 1'b0;
          end
        end
      end

      EMIT: begin
        o_valid      = 1'b1;
        o_word       = acc_q[OUT_WIDTH-1:0];
        o_nbits      = 8'(OUT_WIDTH);
        o_last       = flush_pend_q && (fill_q == FILL_BIT'(OUT_WIDTH));
        flush_pend_d = flush_pend_q | i_flush;
        if (i_ready) begin
          acc_d  = acc_q >> OUT_WIDTH;
          fill_d = fill_q - FILL_BIT'(OUT_WIDTH);
          if (flush_pend_q && (fill_d != '0)) begin
            state_d = FLUSH;
          end else begin
            state_d = FILL;
            if (flush_pend_q) begin
              flush_done_d = 1'b1;
              flush_pend_d = 1'b0;
            end
          end
        end
      end

      FLUSH: begin
        o_valid      = 1'b1;
        o_word       = acc_q[OUT_WIDTH-1:0];
        o_nbits      = fill_q;
        o_last       = 1'b1;
        flush_pend_d = flush_pend_q | i_flush;
        if (i_ready) begin
          acc_d        = '0;
          fill_d       = '0;
          flush_pend_d = 1'b0;
          flush_done_d = 1'b1;
          state_d      = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  assign o_flush_done = flush_done_q;
  assign o_fill       = fill_q;

  a_fill_bound : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    fill_q <= FILL_BIT'(MAX_FILL));

endmodule

// File: tb/tb_word_pack_ctrl.sv
// Self-checking bench for word_pack_ctrl: directed scenarios plus random traffic
// compared against a bit-queue reference model.
module tb_word_pack_ctrl;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_valid;
  logic         o_ready;
  logic [63:0]  i_chunk;
  logic [6:0]   i_len;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_word;
  logic [7:0]   o_nbits;
  logic         o_last;
  logic         o_flush_done;
  logic [7:0]   o_fill;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending bits in arrival order, a flush-requested flag and
  // the flush-done pulse expected in the next cycle.
  bit           mq[$];
  bit           mfl;
  bit           mdone;
  logic [127:0] cap_word;
  logic [7:0]   cap_nbits;

  word_pack_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_chunk     (i_chunk),
    .i_len       (i_len),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_word      (o_word),
    .o_nbits     (o_nbits),
    .o_last      (o_last),
    .o_flush_done(o_flush_done),
    .o_fill      (o_fill)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_valid();
    return (mq.size() >= 128) || (mfl && (mq.size() > 0));
  endfunction

  function automatic int m_nbits();
    return (mq.size() >= 128) ? 128 : mq.size();
  endfunction

  function automatic logic [127:0] m_word();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < m_nbits(); i++) w[i] = mq[i];
    return w;
  endfunction

  // One clock cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic v, input logic [63:0] c, input logic [6:0] l,
                      input logic f, input logic r);
    bit ev, full_word;
    int n, ln;
    ev = m_valid();
    if (ev && r) f = 1'b0;
    i_valid = v; i_chunk = c; i_len = l; i_flush = f; i_ready = r;
    @(negedge i_clk);
    chk("valid", 128'(o_valid), 128'(ev));
    chk("ready", 128'(o_ready), 128'(!ev));
    chk("fill", 128'(o_fill), 128'(mq.size()));
    chk("flush_done", 128'(o_flush_done), 128'(mdone));
    if (ev) begin
      chk("word", o_word, m_word());
      chk("nbits", 128'(o_nbits), 128'(m_nbits()));
      chk("last", 128'(o_last), 128'(mfl && (mq.size() <= 128)));
      if (r) begin
        cap_word  = o_word;
        cap_nbits = o_nbits;
      end
    end
    @(posedge i_clk);
    mdone = 1'b0;
    if (ev && r) begin
      full_word = (mq.size() >= 128);
      n = m_nbits();
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (!full_word || (mfl && mq.size() == 0)) begin
        mfl   = 1'b0;
        mdone = 1'b1;
      end
    end
    if (!ev && v) begin
      ln = (l > 7'd64) ? 64 : int'(l);
      for (int i = 0; i < ln; i++) mq.push_back(c[i]);
    end
    if (f) mfl = 1'b1;
    if (!ev && mfl && mq.size() == 0) begin
      mfl   = 1'b0;
      mdone = 1'b1;
    end
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] a, b, c;
    i_rst_n = 1'b0;
    i_valid = 1'b0; i_chunk = '0; i_len = '0; i_flush = 1'b0; i_ready = 1'b0;
    mfl = 1'b0; mdone = 1'b0; cap_word = '0; cap_nbits = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk("rst_valid", 128'(o_valid), 128'd0);
    chk("rst_ready", 128'(o_ready), 128'd1);
    chk("rst_fill", 128'(o_fill), 128'd0);
    chk("rst_word", o_word, 128'd0);
    chk("rst_last", 128'(o_last), 128'd0);
    chk("rst_done", 128'(o_flush_done), 128'd0);
    @(posedge i_clk); #1;

    // Four 32-bit chunks build one word
    step(1, 64'h11111111, 7'd32, 0, 1);
    step(1, 64'h22222222, 7'd32, 0, 1);
    step(1, 64'h33333333, 7'd32, 0, 1);
    step(1, 64'h44444444, 7'd32, 0, 1);
    step(0, '0, 7'd0, 0, 1);
    chk("t1_word", cap_word, 128'h44444444_33333333_22222222_11111111);
    chk("t1_nbits", 128'(cap_nbits), 128'd128);
    chk("t1_fill", 128'(o_fill), 128'd0);

    // Length saturation and word-boundary crossing
    a = rnd64(); b = rnd64(); c = rnd64();
    step(1, a, 7'd100, 0, 1);
    step(1, b, 7'd60, 0, 1);
    chk("t2_sat_fill", 128'(o_fill), 128'd124);
    step(1, c, 7'd20, 0, 1);
    step(0, '0, 7'd0, 0, 1);
    chk("t2_word", cap_word, {c[3:0], b[59:0], a});
    chk("t2_resid", 128'(o_fill), 128'd16);
    step(0, '0, 7'd0, 1, 1);
    step(0, '0, 7'd0, 0, 1);
    chk("t2_tail", cap_word, 128'(c[19:4]));
    step(0, '0, 7'd0, 0, 1);

    // 60+60+20 leaves a 12-bit residual from chunk 3
    a = rnd64(); b = rnd64(); c = rnd64();
    step(1, a, 7'd60, 0, 1);
    step(1, b, 7'd60, 0, 1);
    step(1, c, 7'd20, 0, 1);
    step(0, '0, 7'd0, 0, 1);
    chk("t3_resid", 128'(o_fill), 128'd12);
    step(0, '0, 7'd0, 1, 1);
    step(0, '0, 7'd0, 0, 1);
    chk("t3_tail", cap_word, 128'(c[19:8]));
    chk("t3_nbits", 128'(cap_nbits), 128'd12);
    step(0, '0, 7'd0, 0, 1);

    // Downstream stall for five cycles while upstream keeps offering
    a = rnd64(); b = rnd64();
    step(1, a, 7'd64, 0, 1);
    step(1, b, 7'd64, 0, 1);
    for (int i = 0; i < 5; i++) step(1, rnd64(), 7'd32, 0, 0);
    step(1, rnd64(), 7'd32, 0, 1);
    chk("t4_word", cap_word, {b, a});
    chk("t4_fill", 128'(o_fill), 128'd0);

    // Chunk and flush in the same cycle
    a = rnd64();
    step(1, a, 7'd40, 1, 1);
    step(0, '0, 7'd0, 0, 1);
    chk("t5_word", cap_word, 128'(a[39:0]));
    chk("t5_nbits", 128'(cap_nbits), 128'd40);
    step(0, '0, 7'd0, 0, 1);

    // Flush with nothing buffered
    step(0, '0, 7'd0, 1, 1);
    step(0, '0, 7'd0, 0, 1);

    // Reset while a word is waiting
    step(1, rnd64(), 7'd64, 0, 1);
    step(1, rnd64(), 7'd64, 0, 1);
    step(0, '0, 7'd0, 0, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t7_valid", 128'(o_valid), 128'd0);
    chk("t7_fill", 128'(o_fill), 128'd0);
    mq.delete(); mfl = 1'b0; mdone = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), rnd64(), 7'($urandom_range(0, 80)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 4; i++) step(0, '0, 7'd0, (i == 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
